// File: rtl/bias_pwrup_seq.sv
// bias_pwrup_seq: power-up sequencer for the bias/bandgap IO cell with bounded retry, loss restart and trim latching
// Ports: CLK_I clock; RST_I async active-high reset; REQ_I level power request; VBIAS_REQ_I VBIAS request;
//        TRIM_*_CFG_I config trims; BG_VALID_N_I async active-low valid; EN_O/BG_STARTUP_O/EN_VBIAS_O/TRIM_*_O
//        drive the cell; READY_O/FAULT_O/LOSS_O status; STATE_O current FSM state
module bias_pwrup_seq #(
  parameter int STARTUP_CYC = 16,
  parameter int SETTLE_CYC  = 64,
  parameter int TIMEOUT_CYC = 256,
  parameter int MAX_RETRY   = 3
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       REQ_I,
  input  logic       VBIAS_REQ_I,
  input  logic [3:0] TRIM_BIAS_CFG_I,
  input  logic [4:0] TRIM_CURV_CFG_I,
  input  logic [4:0] TRIM_VBG_CFG_I,
  input  logic       BG_VALID_N_I,
  output logic       EN_O,
  output logic       BG_STARTUP_O,
  output logic       EN_VBIAS_O,
  output logic [3:0] TRIM_BIAS_O,
  output logic [4:0] TRIM_CURV_O,
  output logic [4:0] TRIM_VBG_O,
  output logic       READY_O,
  output logic       FAULT_O,
  output logic       LOSS_O,
  output logic [2:0] STATE_O
);
  localparam int MAX_CYC = (STARTUP_CYC > SETTLE_CYC) ?
                           ((STARTUP_CYC > TIMEOUT_CYC) ? STARTUP_CYC : TIMEOUT_CYC) :
                           ((SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC);
  localparam int CNT_W = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(STARTUP_CYC - 1);
  localparam logic [CNT_W-1:0] SE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_OFF = 3'd0, S_STARTUP = 3'd1, S_SETTLE = 3'd2, S_VWAIT = 3'd3, S_READY = 3'd4, S_FAULT = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       retry_q, retry_d;
  logic [1:0]       sync_q;
  logic [13:0]      trim_q, trim_d;
  logic             en_q, en_d, bgs_q, bgs_d, envb_q, envb_d, ready_q, ready_d;
  logic             fault_q, fault_d, loss_q, loss_d, drop_q, drop_d, loss_ev, vld;

  assign vld = !sync_q[1];

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_ev = 1'b0;
    if (!REQ_I) state_d = S_OFF;
    else begin
      case (state_q)
        S_OFF: begin
          state_d = S_STARTUP;
          retry_d = '0;
        end
        S_STARTUP: state_d = (cnt_q == ST_LAST) ? S_SETTLE : S_STARTUP;
        S_SETTLE:  state_d = (cnt_q == SE_LAST) ? S_VWAIT : S_SETTLE;
        S_VWAIT: begin
          // valid takes precedence over a timeout landing in the same cycle
          if (vld) state_d = S_READY;
          else if (cnt_q == TO_LAST) begin
            state_d = (retry_q < MAX_R) ? S_STARTUP : S_FAULT;
            retry_d = (retry_q < MAX_R) ? retry_q + 3'd1 : retry_q;
          end
        end
        S_READY: begin
          // drop_q remembers a low vld last cycle, so only two consecutive lows restart
          if (!vld && drop_q) begin
            state_d = S_STARTUP;
            retry_d = '0;
            loss_ev = 1'b1;
          end
        end
        default: ;
      endcase
    end
    cnt_d   = (state_d != state_q) ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
    trim_d  = (state_q == S_OFF && REQ_I) ? {TRIM_BIAS_CFG_I, TRIM_CURV_CFG_I, TRIM_VBG_CFG_I} : trim_q;
    en_d    = state_d inside {S_STARTUP, S_SETTLE, S_VWAIT, S_READY};
    bgs_d   = state_d == S_STARTUP;
    envb_d  = (state_d == S_READY) && VBIAS_REQ_I;
    ready_d = state_d == S_READY;
    fault_d = state_d == S_FAULT;
    loss_d  = (state_d == S_OFF) ? 1'b0 : (loss_q | loss_ev);
    drop_d  = (state_d == S_READY) && !vld;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      retry_q <= '0;
      sync_q  <= 2'b11;
      trim_q  <= '0;
      en_q    <= 1'b0;
      bgs_q   <= 1'b0;
      envb_q  <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      loss_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      sync_q  <= {sync_q[0], BG_VALID_N_I};
      trim_q  <= trim_d;
      en_q    <= en_d;
      bgs_q   <= bgs_d;
      envb_q  <= envb_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
      loss_q  <= loss_d;
      drop_q  <= drop_d;
    end
  end

  assign EN_O         = en_q;
  assign BG_STARTUP_O = bgs_q;
  assign EN_VBIAS_O   = envb_q;
  assign READY_O      = ready_q;
  assign FAULT_O      = fault_q;
  assign LOSS_O       = loss_q;
  assign STATE_O      = state_q;
  assign {TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O} = trim_q;
endmodule

// File: tb/tb_bias_pwrup_seq.sv
// tb_bias_pwrup_seq: directed table and corner-case sequences for bias_pwrup_seq
module tb_bias_pwrup_seq;
  logic       clk = 1'b0, rst = 1'b1, req = 1'b0, vreq = 1'b0, bgn = 1'b1;
  logic [13:0] cfg = '0;
  logic       en_o, bgs_o, envb_o, ready_o, fault_o, loss_o;
  logic [3:0] tb_o;
  logic [4:0] tc_o, tv_o;
  logic [2:0] st_o;
  int n_chk = 0, n_fail = 0;

  localparam logic [13:0] CA = {4'hA, 5'h15, 5'h0C};
  localparam logic [13:0] CB = {4'h3, 5'h0A, 5'h1F};

  bias_pwrup_seq dut (
    .CLK_I(clk), .RST_I(rst), .REQ_I(req), .VBIAS_REQ_I(vreq),
    .TRIM_BIAS_CFG_I(cfg[13:10]), .TRIM_CURV_CFG_I(cfg[9:5]), .TRIM_VBG_CFG_I(cfg[4:0]),
    .BG_VALID_N_I(bgn), .EN_O(en_o), .BG_STARTUP_O(bgs_o), .EN_VBIAS_O(envb_o),
    .TRIM_BIAS_O(tb_o), .TRIM_CURV_O(tc_o), .TRIM_VBG_O(tv_o),
    .READY_O(ready_o), .FAULT_O(fault_o), .LOSS_O(loss_o), .STATE_O(st_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req, vreq, bgn;
    logic [13:0] cfg;
    int          n;
    logic [8:0]  exp_o;
    logic [13:0] exp_trim;
  } vec_t;
  vec_t tv[21];

  // {state, en, bg_startup, en_vbias, ready, fault, loss}
  function automatic logic [8:0] o(input logic [2:0] st, input logic [5:0] f);
    return {st, f};
  endfunction

  function automatic logic [8:0] outs();
    return {st_o, en_o, bgs_o, envb_o, ready_o, fault_o, loss_o};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    int cyc, pulses;
    logic prev;
    tv[0]  = '{1'b1, 1'b0, 1'b1, CA, 1,  o(1, 6'b110000), CA};
    tv[1]  = '{1'b1, 1'b0, 1'b1, CA, 15, o(1, 6'b110000), CA};
    tv[2]  = '{1'b1, 1'b0, 1'b1, CA, 1,  o(2, 6'b100000), CA};
    tv[3]  = '{1'b1, 1'b0, 1'b1, CA, 63, o(2, 6'b100000), CA};
    tv[4]  = '{1'b1, 1'b0, 1'b1, CA, 1,  o(3, 6'b100000), CA};
    tv[5]  = '{1'b1, 1'b0, 1'b1, CA, 9,  o(3, 6'b100000), CA};
    tv[6]  = '{1'b1, 1'b0, 1'b0, CA, 2,  o(3, 6'b100000), CA};
    tv[7]  = '{1'b1, 1'b0, 1'b0, CA, 1,  o(4, 6'b100100), CA};
    tv[8]  = '{1'b1, 1'b1, 1'b0, CB, 1,  o(4, 6'b101100), CA};
    tv[9]  = '{1'b1, 1'b0, 1'b0, CB, 1,  o(4, 6'b100100), CA};
    tv[10] = '{1'b1, 1'b1, 1'b0, CB, 1,  o(4, 6'b101100), CA};
    tv[11] = '{1'b1, 1'b1, 1'b1, CB, 1,  o(4, 6'b101100), CA};
    tv[12] = '{1'b1, 1'b1, 1'b0, CB, 3,  o(4, 6'b101100), CA};
    tv[13] = '{1'b1, 1'b1, 1'b1, CB, 1,  o(4, 6'b101100), CA};
    tv[14] = '{1'b1, 1'b1, 1'b1, CB, 2,  o(4, 6'b101100), CA};
    tv[15] = '{1'b1, 1'b1, 1'b1, CB, 1,  o(1, 6'b110001), CA};
    tv[16] = '{1'b1, 1'b1, 1'b1, CB, 16, o(2, 6'b100001), CA};
    tv[17] = '{1'b1, 1'b1, 1'b1, CB, 10, o(2, 6'b100001), CA};
    tv[18] = '{1'b0, 1'b0, 1'b1, CB, 1,  o(0, 6'b000000), CA};
    tv[19] = '{1'b1, 1'b0, 1'b1, CB, 1,  o(1, 6'b110000), CB};
    tv[20] = '{1'b0, 1'b0, 1'b1, CB, 1,  o(0, 6'b000000), CB};

    #3;
    chk("reset outs", 32'(outs()), 32'(o(0, 6'b000000)));
    chk("reset trims", 32'({tb_o, tc_o, tv_o}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(2);

    for (int i = 0; i < 21; i++) begin
      req = tv[i].req; vreq = tv[i].vreq; bgn = tv[i].bgn; cfg = tv[i].cfg;
      tick(tv[i].n);
      chk($sformatf("vec%0d outs", i), 32'(outs()), 32'(tv[i].exp_o));
      chk($sformatf("vec%0d trims", i), 32'({tb_o, tc_o, tv_o}), 32'(tv[i].exp_trim));
    end

    // timeout on every attempt: 1 + MAX_RETRY startup pulses then FAULT
    cfg = CA; bgn = 1'b1; req = 1'b1; cyc = 0; pulses = 0; prev = 1'b0;
    while (cyc < 2000 && !fault_o) begin
      tick(1);
      cyc++;
      if (bgs_o && !prev) pulses++;
      prev = bgs_o;
    end
    chk("fault cycles", 32'(cyc), 32'd1345);
    chk("startup pulses", 32'(pulses), 32'd4);
    chk("fault outs", 32'(outs()), 32'(o(5, 6'b000010)));
    chk("fault trims", 32'({tb_o, tc_o, tv_o}), 32'(CA));
    tick(5);
    chk("fault held", 32'(outs()), 32'(o(5, 6'b000010)));
    req = 1'b0;
    tick(1);
    chk("fault release", 32'(outs()), 32'(o(0, 6'b000000)));
    tick(2);

    // valid first appears in the third VALID_WAIT
    req = 1'b1;
    tick(760);
    chk("third wait", 32'(outs()), 32'(o(3, 6'b100000)));
    bgn = 1'b0;
    tick(2);
    chk("recover sync", 32'(st_o), 32'd3);
    tick(1);
    chk("recover ready", 32'(outs()), 32'(o(4, 6'b100100)));
    req = 1'b0; bgn = 1'b1;
    tick(3);

    // vld arrives on the exact timeout cycle
    req = 1'b1;
    tick(334);
    bgn = 1'b0;
    tick(2);
    chk("edge wait", 32'(outs()), 32'(o(3, 6'b100000)));
    tick(1);
    chk("edge ready", 32'(outs()), 32'(o(4, 6'b100100)));

    // asynchronous reset while READY with VBIAS on
    vreq = 1'b1;
    tick(1);
    chk("pre-reset vbias", 32'(outs()), 32'(o(4, 6'b101100)));
    #2 rst = 1'b1;
    #1;
    chk("async reset outs", 32'(outs()), 32'(o(0, 6'b000000)));
    chk("async reset trims", 32'({tb_o, tc_o, tv_o}), 32'd0);
    #1 rst = 1'b0;
    req = 1'b0; vreq = 1'b0; bgn = 1'b1;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
